// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with load, prescaler, wrap/saturate modes,
// terminal-count and end-of-range (wrap pulse / sticky overflow) flags.
module counter_updown_mod #(
   parameter int WIDTH    = 4,
   parameter int MOD_MAX  = 15,
   parameter int PRESCALE = 1,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clear_ovf,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             ovf_sticky
);

   localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MOD_MAX);
   localparam logic [WIDTH-1:0] Q_ONE   = WIDTH'(1);
   localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);

   logic [PS_W-1:0]  ps;
   logic [PS_W-1:0]  ps_next;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] load_q;
   logic             step;
   logic             at_end;
   logic             end_event;

   // Clamp only exists when the modulus leaves unreachable codes above it.
   if (MOD_MAX < (2 ** WIDTH) - 1) begin : g_clamp
      assign load_q = (load_val > Q_MAX) ? Q_MAX : load_val;
   end else begin : g_full
      assign load_q = load_val;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      step      = en && (ps == PS_LAST);
      at_end    = up ? (q == Q_MAX) : (q == '0);
      end_event = step && at_end;
      ps_next   = step ? '0 : ps + PS_ONE;
      q_next    = q;
      if (!at_end) begin
         q_next = up ? q + Q_ONE : q - Q_ONE;
      end else if (SATURATE == 0) begin
         q_next = up ? '0 : Q_MAX;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         q          <= '0;
         ps         <= '0;
         wrap       <= 1'b0;
         ovf_sticky <= 1'b0;
      end else if (load) begin
         q    <= load_q;
         ps   <= '0;
         wrap <= 1'b0;
         if (clear_ovf) ovf_sticky <= 1'b0;
      end else begin
         wrap <= end_event;
         // Setting on an end event beats a simultaneous clear.
         if (end_event)      ovf_sticky <= 1'b1;
         else if (clear_ovf) ovf_sticky <= 1'b0;
         if (en) begin
            ps <= ps_next;
            if (step) q <= q_next;
         end
      end
   end

   assign tc = up ? (q == Q_MAX) : (q == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Self-checking bench: four counter variants share one stimulus stream and are
// compared every cycle against an arithmetic reference model.
module tb_counter_updown_mod;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic       up = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_val = '0;
   logic       clear_ovf = 1'b0;

   logic [3:0] q_o    [4];
   logic       tc_o   [4];
   logic       wrap_o [4];
   logic       ovf_o  [4];

   int total = 0;
   int bad   = 0;

   // Variant table: 0 default, 1 mod-10 wrap, 2 mod-10 saturate, 3 prescale-by-3.
   int p_mod [4] = '{15, 9, 9, 15};
   int p_pre [4] = '{1, 1, 1, 3};
   int p_sat [4] = '{0, 0, 1, 0};

   int mq   [4];
   int mcnt [4];
   bit mwrap[4];
   bit movf [4];

   always #5 clk = ~clk;

   counter_updown_mod #(.WIDTH(4), .MOD_MAX(15), .PRESCALE(1), .SATURATE(0)) d0 (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .clear_ovf(clear_ovf), .q(q_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0]), .ovf_sticky(ovf_o[0]));
   counter_updown_mod #(.WIDTH(4), .MOD_MAX(9), .PRESCALE(1), .SATURATE(0)) d1 (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .clear_ovf(clear_ovf), .q(q_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1]), .ovf_sticky(ovf_o[1]));
   counter_updown_mod #(.WIDTH(4), .MOD_MAX(9), .PRESCALE(1), .SATURATE(1)) d2 (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .clear_ovf(clear_ovf), .q(q_o[2]), .tc(tc_o[2]), .wrap(wrap_o[2]), .ovf_sticky(ovf_o[2]));
   counter_updown_mod #(.WIDTH(4), .MOD_MAX(15), .PRESCALE(3), .SATURATE(0)) d3 (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .clear_ovf(clear_ovf), .q(q_o[3]), .tc(tc_o[3]), .wrap(wrap_o[3]), .ovf_sticky(ovf_o[3]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: count enabled edges, step on every p_pre-th one.
   task automatic model_step();
      for (int i = 0; i < 4; i++) begin
         bit ev = 0;
         if (reset) begin
            mq[i] = 0; mcnt[i] = 0; mwrap[i] = 0; movf[i] = 0;
         end else if (load) begin
            mq[i]    = (int'(load_val) > p_mod[i]) ? p_mod[i] : int'(load_val);
            mcnt[i]  = 0;
            mwrap[i] = 0;
            if (clear_ovf) movf[i] = 0;
         end else begin
            if (en) begin
               mcnt[i]++;
               if (mcnt[i] == p_pre[i]) begin
                  mcnt[i] = 0;
                  if (up) begin
                     if (mq[i] == p_mod[i]) begin ev = 1; if (p_sat[i] == 0) mq[i] = 0; end
                     else mq[i] = mq[i] + 1;
                  end else begin
                     if (mq[i] == 0) begin ev = 1; if (p_sat[i] == 0) mq[i] = p_mod[i]; end
                     else mq[i] = mq[i] - 1;
                  end
               end
            end
            mwrap[i] = ev;
            if (ev) movf[i] = 1;
            else if (clear_ovf) movf[i] = 0;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 4; i++) begin
         bit exp_tc = up ? (mq[i] == p_mod[i]) : (mq[i] == 0);
         check($sformatf("q%0d", i), 32'(q_o[i]), 32'(mq[i]));
         check($sformatf("tc%0d", i), 32'(tc_o[i]), 32'(exp_tc));
         check($sformatf("wrap%0d", i), 32'(wrap_o[i]), 32'(mwrap[i]));
         check($sformatf("ovf%0d", i), 32'(ovf_o[i]), 32'(movf[i]));
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      int exp_b [4] = '{1, 0, 9, 8};
      int exp_c [5] = '{8, 9, 9, 9, 9};
      int wrp_c [5] = '{0, 0, 1, 1, 1};
      int exp_d [5] = '{0, 0, 0, 0, 1};

      // Default variant: wrap-around count from reset.
      tick();
      reset = 1'b0; en = 1'b1; up = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("a_q", 32'(q_o[0]), 32'((i + 1) % 16));
         check("a_wrap", 32'(wrap_o[0]), 32'(i == 15));
         check("a_tc", 32'(tc_o[0]), 32'(((i + 1) % 16) == 15));
         check("a_ovf", 32'(ovf_o[0]), 32'(i >= 15));
      end

      // Mod-10 down count through zero.
      en = 1'b0; load = 1'b1; load_val = 4'd2;
      tick();
      check("b_load", 32'(q_o[1]), 32'd2);
      load = 1'b0; en = 1'b1; up = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("b_q", 32'(q_o[1]), 32'(exp_b[i]));
         check("b_wrap", 32'(wrap_o[1]), 32'(exp_b[i] == 9));
         check("b_tc", 32'(tc_o[1]), 32'(exp_b[i] == 0));
      end

      // Load clamp above the modulus.
      en = 1'b0; load = 1'b1; load_val = 4'd12;
      tick();
      check("clamp_q1", 32'(q_o[1]), 32'd9);
      check("clamp_q0", 32'(q_o[0]), 32'd12);

      // Saturating variant held at the top.
      load_val = 4'd7;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("c_q", 32'(q_o[2]), 32'(exp_c[i]));
         check("c_wrap", 32'(wrap_o[2]), 32'(wrp_c[i]));
      end

      // Prescale by 3: one step every third enabled edge.
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
         check("d_q", 32'(q_o[3]), 32'((i + 1) / 3));
      end

      // Dropping en for two cycles delays the step by two.
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         en = (i == 1 || i == 2) ? 1'b0 : 1'b1;
         tick();
         check("d_hold", 32'(q_o[3]), 32'(exp_d[i]));
      end

      // Load on the prescaler terminal edge wins over the step.
      reset = 1'b1; en = 1'b0; tick(); reset = 1'b0; en = 1'b1;
      tick(); tick();
      load = 1'b1; load_val = 4'd5;
      tick();
      check("e_q", 32'(q_o[3]), 32'd5);
      check("e_wrap", 32'(wrap_o[3]), 32'd0);
      load = 1'b0;
      tick(); tick();
      check("e_restart", 32'(q_o[3]), 32'd5);
      tick();
      check("e_step", 32'(q_o[3]), 32'd6);

      // Set beats clear when both land on one edge.
      reset = 1'b1; en = 1'b0; tick(); reset = 1'b0;
      load = 1'b1; load_val = 4'd15; tick(); load = 1'b0;
      en = 1'b1; up = 1'b1; clear_ovf = 1'b1;
      tick();
      check("f_q", 32'(q_o[0]), 32'd0);
      check("f_wrap", 32'(wrap_o[0]), 32'd1);
      check("f_ovf", 32'(ovf_o[0]), 32'd1);
      en = 1'b0;
      tick();
      check("f_clr", 32'(ovf_o[0]), 32'd0);
      clear_ovf = 1'b0;

      // Reset mid-prescale.
      load = 1'b1; load_val = 4'd5; tick(); load = 1'b0;
      en = 1'b1; tick();
      check("g_pre", 32'(q_o[3]), 32'd5);
      up = 1'b0; reset = 1'b1;
      tick();
      check("g_q", 32'(q_o[3]), 32'd0);
      check("g_wrap", 32'(wrap_o[3]), 32'd0);
      check("g_ovf", 32'(ovf_o[3]), 32'd0);
      check("g_tc", 32'(tc_o[3]), 32'd1);
      reset = 1'b0; up = 1'b1;
      tick(); tick();
      check("g_wait", 32'(q_o[3]), 32'd0);
      tick();
      check("g_step", 32'(q_o[3]), 32'd1);

      // Random traffic against the model.
      for (int n = 0; n < 800; n++) begin
         reset     = ($urandom_range(0, 49) == 0);
         load      = ($urandom_range(0, 9) == 0);
         load_val  = 4'($urandom_range(0, 15));
         en        = ($urandom_range(0, 3) != 0);
         clear_ovf = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 7) == 0) up = ~up;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
